// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer: widths, opcodes,
// flag bit positions and FSM state encodings.
package alu_op_sequencer_pkg;

  localparam int DATA_W     = 8;
  localparam int OPER_W     = 4;
  localparam int FLAGS_W    = 4;
  localparam int REG_ADDR_W = 4;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;

  typedef enum logic [OPER_W-1:0] {
    OP_ADD = 4'd0,
    OP_ADC = 4'd1,
    OP_SUB = 4'd2,
    OP_SBC = 4'd3,
    OP_CMP = 4'd4,
    OP_AND = 4'd5,
    OP_ORR = 4'd6,
    OP_XOR = 4'd7,
    OP_LSR = 4'd8
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } seq_state_e;

  function automatic logic oper_known(input logic [OPER_W-1:0] op);
    return op <= OP_LSR;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_regfile.sv
// Register file: one write port, two registered read ports (enable-gated)
// and one asynchronous debug read port. Sync reset clears every entry.
module alu_op_sequencer_regfile #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr_a,
  input  logic [ADDR_WIDTH-1:0] raddr_b,
  output logic [DATA_WIDTH-1:0] rdata_a,
  output logic [DATA_WIDTH-1:0] rdata_b,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem     <= '0;
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      if (we) mem[waddr] <= wdata;
      if (re) begin
        rdata_a <= mem[raddr_a];
        rdata_b <= mem[raddr_b];
      end
    end
  end

  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU command sequencer: accept -> read operands -> drive ALU -> write back.
// One command in flight; done pulses three cycles after accept.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH     = alu_op_sequencer_pkg::DATA_W,
  parameter int OPER_WIDTH     = alu_op_sequencer_pkg::OPER_W,
  parameter int FLAGS_WIDTH    = alu_op_sequencer_pkg::FLAGS_W,
  parameter int REG_ADDR_WIDTH = alu_op_sequencer_pkg::REG_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [OPER_WIDTH-1:0]     cmd_oper,
  input  logic [REG_ADDR_WIDTH-1:0] cmd_rd,
  input  logic [REG_ADDR_WIDTH-1:0] cmd_ra,
  input  logic [REG_ADDR_WIDTH-1:0] cmd_rb,
  input  logic                      ld_en,
  input  logic [REG_ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0]     ld_data,
  output logic [OPER_WIDTH-1:0]     alu_oper,
  output logic [DATA_WIDTH-1:0]     alu_a,
  output logic [DATA_WIDTH-1:0]     alu_b,
  output logic [FLAGS_WIDTH-1:0]    alu_flags_in,
  input  logic [DATA_WIDTH-1:0]     alu_out,
  input  logic [FLAGS_WIDTH-1:0]    alu_flags_out,
  output logic                      done,
  output logic                      bad_oper,
  output logic [DATA_WIDTH-1:0]     result,
  output logic [FLAGS_WIDTH-1:0]    flags,
  input  logic [REG_ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0]     dbg_data
);

  seq_state_e state, state_nxt;

  logic [OPER_WIDTH-1:0]     oper_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q, ra_q, rb_q;
  logic [DATA_WIDTH-1:0]     opa, opb, result_q;
  logic [FLAGS_WIDTH-1:0]    flags_q;
  logic                      cap_c, cap_z;
  logic                      accept, known, writes_rd;

  logic                      rf_we;
  logic [REG_ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0]     rf_wdata;

  assign accept    = cmd_valid && (state == ST_IDLE);
  assign known     = oper_known(oper_q);
  // CMP only sets flags; its ALU output is meaningless
  assign writes_rd = known && (oper_q != OP_CMP);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_READ;
      ST_READ: state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_WB;
      ST_WB:   state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    cmd_ready    = 1'b0;
    done         = 1'b0;
    bad_oper     = 1'b0;
    alu_oper     = '0;
    alu_a        = '0;
    alu_b        = '0;
    alu_flags_in = '0;
    case (state)
      ST_IDLE: cmd_ready = 1'b1;
      ST_EXEC: begin
        alu_oper     = oper_q;
        alu_a        = opa;
        alu_b        = opb;
        alu_flags_in = flags_q;
      end
      ST_WB: begin
        done     = 1'b1;
        bad_oper = !known;
      end
      default: ;
    endcase
  end

  // External loads share the write port with writeback; they never overlap
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = ld_addr;
    rf_wdata = ld_data;
    if (state == ST_WB) begin
      rf_we    = writes_rd;
      rf_waddr = rd_q;
      rf_wdata = result_q;
    end else if (state == ST_IDLE) begin
      rf_we = ld_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      oper_q   <= '0;
      rd_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      result_q <= '0;
      cap_c    <= 1'b0;
      cap_z    <= 1'b0;
      flags_q  <= '0;
    end else begin
      if (accept) begin
        oper_q <= cmd_oper;
        rd_q   <= cmd_rd;
        ra_q   <= cmd_ra;
        rb_q   <= cmd_rb;
      end
      if (state == ST_EXEC) begin
        cap_c <= alu_flags_out[FLAG_C];
        cap_z <= alu_flags_out[FLAG_Z];
        if (writes_rd) result_q <= alu_out;
      end
      if (state == ST_WB && known) begin
        flags_q[FLAG_C] <= cap_c;
        flags_q[FLAG_Z] <= cap_z;
      end
    end
  end

  alu_op_sequencer_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata),
    .re       (state == ST_READ),
    .raddr_a  (ra_q),
    .raddr_b  (rb_q),
    .rdata_a  (opa),
    .rdata_b  (opb),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  assign result = result_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU, reference model with a
// scoreboard queue, directed cases followed by randomized commands.
module tb_alu_op_sequencer;
  import alu_op_sequencer_pkg::*;

  localparam int DW = 8;
  localparam int OW = 4;
  localparam int FW = 4;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [OW-1:0] cmd_oper = '0;
  logic [AW-1:0] cmd_rd = '0, cmd_ra = '0, cmd_rb = '0;
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic [OW-1:0] alu_oper;
  logic [DW-1:0] alu_a, alu_b, alu_out;
  logic [FW-1:0] alu_flags_in, alu_flags_out;
  logic          done, bad_oper;
  logic [DW-1:0] result;
  logic [FW-1:0] flags;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_data;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_oper(cmd_oper),
    .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_oper(alu_oper), .alu_a(alu_a), .alu_b(alu_b), .alu_flags_in(alu_flags_in),
    .alu_out(alu_out), .alu_flags_out(alu_flags_out),
    .done(done), .bad_oper(bad_oper), .result(result), .flags(flags),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Behavioural ALU: returns {flags, result}. Non-C/Z flag bits come back
  // inverted so a sequencer that fails to mask them is caught.
  function automatic logic [FW+DW-1:0] alu_f(input logic [OW-1:0] op,
      input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [FW-1:0] fin);
    logic [DW:0]   s;
    logic [FW-1:0] fo;
    logic          c;
    c = fin[FLAG_C];
    s = {1'b0, a ^ b};
    case (op)
      OP_ADD: begin s = {1'b0, a} + {1'b0, b};                 c = s[DW]; end
      OP_ADC: begin s = {1'b0, a} + {1'b0, b} + fin[FLAG_C];   c = s[DW]; end
      OP_SUB, OP_CMP:
              begin s = {1'b0, a} + {1'b0, ~b} + 1'b1;          c = s[DW]; end
      OP_SBC: begin s = {1'b0, a} + {1'b0, ~b} + fin[FLAG_C];  c = s[DW]; end
      OP_AND: s = {1'b0, a & b};
      OP_ORR: s = {1'b0, a | b};
      OP_XOR: s = {1'b0, a ^ b};
      OP_LSR: begin s = {1'b0, a >> 1}; c = a[0]; end
      default: ;
    endcase
    fo = ~fin;
    fo[FLAG_C] = c;
    fo[FLAG_Z] = (s[DW-1:0] == '0);
    return {fo, s[DW-1:0]};
  endfunction

  logic [FW+DW-1:0] alu_res;
  always_comb begin
    alu_res       = alu_f(alu_oper, alu_a, alu_b, alu_flags_in);
    alu_out       = alu_res[DW-1:0];
    if (alu_oper == OP_CMP) alu_out = alu_res[DW-1:0] ^ 8'h5A;
    alu_flags_out = alu_res[FW+DW-1:DW];
  end

  // Reference model
  logic [DW-1:0] m_regs [16];
  logic [FW-1:0] m_flags;
  logic [DW-1:0] m_result;

  typedef struct {
    logic [DW-1:0] res;
    logic [FW-1:0] flg;
    logic          bad;
  } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_flags  = '0;
    m_result = '0;
  endtask

  task automatic model_cmd(input logic [OW-1:0] op, input logic [AW-1:0] rd,
                           input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    logic [FW+DW-1:0] r;
    logic             known;
    exp_t             e;
    r     = alu_f(op, m_regs[ra], m_regs[rb], m_flags);
    known = (op <= 4'd8);
    if (known && op != OP_CMP) begin
      m_regs[rd] = r[DW-1:0];
      m_result   = r[DW-1:0];
    end
    if (known) begin
      m_flags[FLAG_C] = r[DW+FLAG_C];
      m_flags[FLAG_Z] = r[DW+FLAG_Z];
    end
    e.res = m_result;
    e.flg = m_flags;
    e.bad = !known;
    sb.push_back(e);
  endtask

  // Monitor: pops an expectation whenever done is seen
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done=1 expected no pending command at %0t", $time);
        end else begin
          e = sb.pop_front();
          chk("result", result, e.res);
          chk("bad_oper", bad_oper, e.bad);
          @(negedge clk);
          chk("flags", flags, e.flg);
          chk("done_pulse", done, 0);
        end
      end
    end
  end

  task automatic ld(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    m_regs[a] = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic check_reg(input string nm, input logic [AW-1:0] a);
    dbg_addr = a;
    #1 chk(nm, dbg_data, m_regs[a]);
  endtask

  // Full command; optional load in the accept cycle and stray loads while busy
  task automatic issue(input logic [OW-1:0] op, input logic [AW-1:0] rd,
                       input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                       input bit do_ld, input logic [AW-1:0] la,
                       input logic [DW-1:0] ldd, input bit stray);
    @(negedge clk);
    chk("ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_oper = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb;
    if (do_ld) begin
      ld_en = 1'b1; ld_addr = la; ld_data = ldd;
      m_regs[la] = ldd;
    end
    model_cmd(op, rd, ra, rb);
    @(negedge clk);
    cmd_valid = 1'b0; ld_en = 1'b0;
    chk("ready_busy", cmd_ready, 0);
    chk("done_read", done, 0);
    if (stray) begin
      ld_en = 1'b1; ld_addr = rd; ld_data = DW'($urandom);
    end
    @(negedge clk);
    chk("done_exec", done, 0);
    @(negedge clk);
    chk("done_latency", done, 1);
    @(negedge clk);
    ld_en = 1'b0;
    check_reg("rf_dest", rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int acc;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_bad", bad_oper, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", flags, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_oper", alu_oper, 0);
    check_reg("rst_reg5", 4'd5);

    ld(4'd1, 8'hF0); ld(4'd2, 8'h20);
    issue(OP_ADD, 4'd3, 4'd1, 4'd2, 0, 0, 0, 0);
    ld(4'd4, 8'h55); ld(4'd5, 8'h55);
    issue(OP_CMP, 4'd6, 4'd4, 4'd5, 0, 0, 0, 0);
    issue(OP_AND, 4'd7, 4'd1, 4'd2, 0, 0, 0, 0);
    ld(4'd8, 8'h01);
    issue(OP_LSR, 4'd8, 4'd8, 4'd3, 0, 0, 0, 0);
    issue(4'hC, 4'd1, 4'd1, 4'd2, 0, 0, 0, 1);
    check_reg("bad_no_write", 4'd1);
    issue(OP_SUB, 4'd9, 4'd11, 4'd2, 1, 4'd11, 8'h05, 1);

    // cmd_valid held for 8 cycles: accepts only in IDLE
    @(negedge clk);
    cmd_valid = 1'b1; cmd_oper = OP_ADC; cmd_rd = 4'd9; cmd_ra = 4'd9; cmd_rb = 4'd2;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      chk("ready_pattern", cmd_ready, (i % 4 == 0) ? 1 : 0);
      if (i % 4 == 0) begin acc++; model_cmd(OP_ADC, 4'd9, 4'd9, 4'd2); end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    check_reg("held_r9", 4'd9);
    chk("held_sb_drained", sb.size(), 0);

    // Reset during EXEC aborts the command
    @(negedge clk);
    cmd_valid = 1'b1; cmd_oper = OP_ADD; cmd_rd = 4'd10; cmd_ra = 4'd1; cmd_rb = 4'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("abort_done", done, 0);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_flags", flags, 0);
    chk("abort_result", result, 0);
    check_reg("abort_r10", 4'd10);
    check_reg("abort_r1", 4'd1);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) ld(AW'($urandom), DW'($urandom));
      issue(OW'($urandom_range(0, 10)), AW'($urandom), AW'($urandom), AW'($urandom),
            ($urandom_range(0, 3) == 0), AW'($urandom), DW'($urandom),
            ($urandom_range(0, 1) == 1));
    end

    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
